// File: rtl/spi_pixel_master.sv
// SPI mode-0 master that sends 4-byte pixel-write packets MSB first.
// CSel is framed per byte; every output comes straight from a flop.
module spi_pixel_master #(
  parameter int HalfPeriod = 2,
  parameter int ByteGap    = 2,
  parameter int PacketGap  = 8
) (
  input  logic        MainClkSrc,
  input  logic        NReset,
  input  logic [31:0] CmdData,
  input  logic        CmdValid,
  output logic        CmdReady,
  output logic        Busy,
  output logic        Done,
  output logic        Sclk,
  output logic        Mosi,
  output logic        CSel
);
  localparam int MaxHb  = (HalfPeriod > ByteGap) ? HalfPeriod : ByteGap;
  localparam int MaxLen = (MaxHb > PacketGap) ? MaxHb : PacketGap;
  localparam int CntW   = $clog2(MaxLen + 1);
  localparam logic [CntW-1:0] HalfLd = CntW'(HalfPeriod - 1);
  localparam logic [CntW-1:0] ByteLd = CntW'(ByteGap - 1);
  localparam logic [CntW-1:0] PktLd  = CntW'(PacketGap - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [31:0]     shift_q, shift_d;
  logic            ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic            sclk_q, sclk_d, mosi_q, mosi_d, csel_q, csel_d;
  logic            accept, cnt_zero;

  assign accept   = (state_q == IDLE) && CmdValid && ready_q;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge MainClkSrc or negedge NReset) begin
    if (!NReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csel_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csel_q  <= csel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOW;
      LOW:     if (cnt_zero) state_d = HIGH;
      HIGH:    if (cnt_zero) state_d = (bit_q == 3'd7) ? GAP : LOW;
      GAP:     if (cnt_zero) state_d = (byte_q == 2'd3) ? IDLE : LOW;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csel_d  = csel_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          shift_d = CmdData;
          bit_d   = '0;
          byte_d  = '0;
          cnt_d   = HalfLd;
          csel_d  = 1'b0;
          mosi_d  = CmdData[31];
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      LOW: begin
        if (cnt_zero) begin
          sclk_d = 1'b1;
          cnt_d  = HalfLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HIGH: begin
        if (cnt_zero) begin
          sclk_d  = 1'b0;
          shift_d = {shift_q[30:0], 1'b0};
          if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            mosi_d = shift_q[30];
            cnt_d  = HalfLd;
          end else begin
            csel_d = 1'b1;
            mosi_d = 1'b0;
            cnt_d  = (byte_q == 2'd3) ? PktLd : ByteLd;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          if (byte_q != 2'd3) begin
            // shift register already holds the next byte at the top
            byte_d = byte_q + 2'd1;
            bit_d  = '0;
            csel_d = 1'b0;
            mosi_d = shift_q[31];
            cnt_d  = HalfLd;
          end else begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign CmdReady = ready_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Sclk     = sclk_q;
  assign Mosi     = mosi_q;
  assign CSel     = csel_q;
endmodule

// File: tb/tb_spi_pixel_master.sv
// Directed bench for spi_pixel_master: two instances (HalfPeriod 1 and 3)
// observed by one SPI decoder that records bytes, CSel windows and timing.
module tb_spi_pixel_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, valid_a, valid_b;
  logic [31:0] data_a, data_b;
  logic        ready_a, busy_a, done_a, sclk_a, mosi_a, csel_a;
  logic        ready_b, busy_b, done_b, sclk_b, mosi_b, csel_b;

  spi_pixel_master #(.HalfPeriod(1), .ByteGap(1), .PacketGap(8)) u_a (
    .MainClkSrc(clk), .NReset(rst_a), .CmdData(data_a), .CmdValid(valid_a),
    .CmdReady(ready_a), .Busy(busy_a), .Done(done_a),
    .Sclk(sclk_a), .Mosi(mosi_a), .CSel(csel_a));

  spi_pixel_master #(.HalfPeriod(3), .ByteGap(2), .PacketGap(8)) u_b (
    .MainClkSrc(clk), .NReset(rst_b), .CmdData(data_b), .CmdValid(valid_b),
    .CmdReady(ready_b), .Busy(busy_b), .Done(done_b),
    .Sclk(sclk_b), .Mosi(mosi_b), .CSel(csel_b));

  int   sel = 0;
  logic m_rst, m_sclk, m_mosi, m_csel, m_busy, m_done;
  assign m_rst  = (sel != 0) ? rst_b  : rst_a;
  assign m_sclk = (sel != 0) ? sclk_b : sclk_a;
  assign m_mosi = (sel != 0) ? mosi_b : mosi_a;
  assign m_csel = (sel != 0) ? csel_b : csel_a;
  assign m_busy = (sel != 0) ? busy_b : busy_a;
  assign m_done = (sel != 0) ? done_b : done_a;

  logic [7:0] bytes_q[$];
  int lows_q[$], highs_q[$], acc_q[$], done_q[$];
  int ncyc = 0, viol = 0, lvl_bad = 0, lvl_n = 0, rises = 0, done_hi = 0;
  int total = 0, bad = 0;

  // Decoder: samples on the falling clock edge, away from DUT updates.
  initial begin
    logic [7:0] bits;
    int nbit, run, lvl;
    logic p_sclk, p_mosi, p_csel, p_busy, p_done;
    bits = '0; nbit = 0; run = 0; lvl = 0;
    p_sclk = 1'b0; p_mosi = 1'b0; p_csel = 1'b1; p_busy = 1'b0; p_done = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!m_rst) begin
        bits = '0; nbit = 0; lvl = 0;
      end else begin
        if (m_sclk && !p_sclk) begin
          bits = {bits[6:0], m_mosi};
          nbit++;
          rises++;
          if (nbit == 8) begin
            bytes_q.push_back(bits);
            nbit = 0;
          end
        end
        if (m_sclk && p_sclk && (m_mosi != p_mosi)) viol++;
        if (m_sclk && m_csel) viol++;
        if (m_csel == p_csel) run++;
        else begin
          if (m_csel) lows_q.push_back(run);
          else        highs_q.push_back(run);
          run = 1;
        end
        if (m_csel) lvl = 0;
        else if (m_sclk != p_sclk) begin
          if (lvl != 0) begin
            lvl_n++;
            if (lvl != ((sel != 0) ? 3 : 1)) lvl_bad++;
          end
          lvl = 1;
        end else lvl++;
        if (m_busy && !p_busy) acc_q.push_back(ncyc);
        if (m_done && !p_done) done_q.push_back(ncyc);
        if (m_done) done_hi++;
      end
      p_sclk = m_sclk; p_mosi = m_mosi; p_csel = m_csel;
      p_busy = m_busy; p_done = m_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin tick(); k++; end
    check("accept_wait", acc_q.size(), n);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_q.size() < n && k < budget) begin tick(); k++; end
    check("done_wait", done_q.size(), n);
  endtask

  task automatic clear_mon();
    bytes_q.delete(); lows_q.delete(); highs_q.delete();
    acc_q.delete(); done_q.delete();
  endtask

  initial begin
    logic [7:0] exp_ab[8];
    logic [7:0] exp_b[4];
    logic [7:0] exp_r[4];
    int v0, l0, ln0, d0, r0, k;
    exp_ab = '{8'h41, 8'hC0, 8'hC0, 8'hC0, 8'h41, 8'h03, 8'h03, 8'h03};
    exp_b  = '{8'hA5, 8'h00, 8'h00, 8'h00};
    exp_r  = '{8'h41, 8'hFF, 8'hFF, 8'hFF};
    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;

    // reset values {Sclk,Mosi,CSel,CmdReady,Busy,Done}
    tick(); tick();
    check("reset_a", {sclk_a, mosi_a, csel_a, ready_a, busy_a, done_a}, 6'b001000);
    check("reset_b", {sclk_b, mosi_b, csel_b, ready_b, busy_b, done_b}, 6'b001000);
    rst_a = 1'b1; rst_b = 1'b1;
    check("ready_before_edge", ready_a, 1'b0);
    tick();
    check("ready_after_edge_a", ready_a, 1'b1);
    check("ready_after_edge_b", ready_b, 1'b1);

    // back-to-back packets on the HalfPeriod=1 instance
    clear_mon();
    v0 = viol; l0 = lvl_bad; ln0 = lvl_n; d0 = done_hi;
    data_a = 32'h41C0C0C0; valid_a = 1'b1;
    wait_acc(1, 20);
    data_a = 32'h41030303;
    wait_acc(2, 300);
    valid_a = 1'b0;
    wait_done(2, 300);
    repeat (4) tick();
    check("b2b_nbytes", bytes_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("b2b_byte%0d", i), bytes_q[i], exp_ab[i]);
    check("b2b_nlow", lows_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("b2b_low%0d", i), lows_q[i], 16);
    check("b2b_nhigh", highs_q.size(), 8);
    for (int i = 1; i < 8; i++) check($sformatf("b2b_high%0d", i), highs_q[i], (i == 4) ? 9 : 1);
    check("pkt1_latency", done_q[0] - acc_q[0], 75);
    check("accept_on_done", acc_q[1] - done_q[0], 1);
    check("pkt2_latency", done_q[1] - acc_q[1], 75);
    check("done_width", done_hi - d0, 2);
    check("b2b_viol", viol - v0, 0);
    check("b2b_lvl_bad", lvl_bad - l0, 0);
    check("b2b_lvl_n", lvl_n - ln0, 120);

    // HalfPeriod=3 instance, CmdData scrambled after accept
    sel = 1;
    tick();
    clear_mon();
    v0 = viol; l0 = lvl_bad; ln0 = lvl_n;
    data_b = 32'hA5000000; valid_b = 1'b1;
    wait_acc(1, 20);
    valid_b = 1'b0; data_b = 32'hFFFFFFFF;
    wait_done(1, 400);
    repeat (2) tick();
    check("hp3_nbytes", bytes_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("hp3_byte%0d", i), bytes_q[i], exp_b[i]);
    check("hp3_lvl_bad", lvl_bad - l0, 0);
    check("hp3_lvl_n", lvl_n - ln0, 60);
    check("hp3_viol", viol - v0, 0);
    check("hp3_latency", done_q[0] - acc_q[0], 206);
    for (int i = 0; i < 4; i++) check($sformatf("hp3_low%0d", i), lows_q[i], 48);

    // reset during HIGH of byte 1 bit 4
    sel = 0;
    tick();
    clear_mon();
    r0 = rises;
    data_a = 32'h12345678; valid_a = 1'b1;
    wait_acc(1, 20);
    valid_a = 1'b0;
    k = 0;
    while ((rises - r0) < 13 && k < 100) begin tick(); k++; end
    check("rst_reach_bit", rises - r0, 13);
    check("rst_in_high", {sclk_a, csel_a}, 2'b10);
    rst_a = 1'b0;
    #1;
    check("rst_async", {sclk_a, csel_a, busy_a, ready_a}, 4'b0100);
    repeat (3) tick();
    check("rst_no_done", done_a, 1'b0);
    rst_a = 1'b1;
    tick();
    check("rst_ready", ready_a, 1'b1);
    repeat (3) tick();
    check("rst_no_done_pulse", done_q.size(), 0);
    bytes_q.delete(); acc_q.delete();
    data_a = 32'h41FFFFFF; valid_a = 1'b1;
    wait_acc(1, 20);
    valid_a = 1'b0;
    wait_done(1, 200);
    repeat (2) tick();
    check("rst_nbytes", bytes_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("rst_byte%0d", i), bytes_q[i], exp_r[i]);

    // idle with CmdValid low and CmdData wandering
    for (int i = 0; i < 50; i++) begin
      data_a = $urandom;
      tick();
      check("idle", {sclk_a, csel_a, busy_a, ready_a}, 4'b0101);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_pixel_master.md
Name: spi_pixel_master

Overview:
- SPI mode-0 master that serialises 4-byte pixel-write packets (command byte plus three payload bytes) towards the vga module's Sclk/Mosi/CSel slave port.
- Sits on the host/controller side, in the controller FPGA or as a bench driver, and replaces hand-toggled pin stimulus.
- Accepts one 32-bit packet via valid/ready and emits it MSB first.
- CSel is framed per byte: low for each byte, high between bytes.

Parameters:
HalfPeriod, 2, MainClkSrc cycles per Sclk phase (low or high); legal range >= 1
ByteGap, 2, MainClkSrc cycles CSel stays high between bytes within a packet; legal range >= 1
PacketGap, 8, MainClkSrc cycles CSel stays high after the 4th byte before the next packet can start; legal range >= 1

Ports:
MainClkSrc  input  1  system clock; all logic on the rising edge
NReset  input  1  asynchronous, active-low reset
CmdData  input  32  packet; [31:24] is sent first, MSB first
CmdValid  input  1  packet available
CmdReady  output  1  block idle and accepting a packet
Busy  output  1  transfer or gap in progress
Done  output  1  one-cycle pulse when a packet plus its PacketGap completes
Sclk  output  1  SPI clock, idles low
Mosi  output  1  SPI data; changes only while Sclk is low
CSel  output  1  active-low byte select, idles high

Behaviour:
- Reset values (async, while NReset=0): Sclk=0, Mosi=0, CSel=1, CmdReady=0, Busy=0, Done=0. State=IDLE, shift register and counters cleared.
- CmdReady rises on the first clock edge after NReset deasserts.
- All outputs are registered.
- States: IDLE, LOW, HIGH, GAP.
- IDLE:
  - CmdReady=1, Busy=0.
  - On CmdValid&&CmdReady at an edge: load shift register with CmdData, bit=0, byte=0, go to LOW.
  - On that same edge: CSel<=0, Mosi<=CmdData[31], CmdReady<=0, Busy<=1.
  - CmdData is ignored at all other times.
- LOW:
  - Sclk=0, lasts HalfPeriod cycles.
  - Then Sclk<=1 and go to HIGH.
- HIGH:
  - Sclk=1, lasts HalfPeriod cycles. The slave samples on the rising edge.
  - At the end of HIGH, Sclk<=0 and the shift register shifts left by 1.
  - If bit<7: bit++, Mosi<=next MSB, go to LOW.
  - If bit==7: CSel<=1, Mosi<=0, go to GAP with length ByteGap (byte<3) or PacketGap (byte==3).
- GAP:
  - Sclk=0, CSel=1.
  - After the gap length, if byte<3: byte++, bit=0, CSel<=0, Mosi<=next MSB, go to LOW.
  - If byte==3: Done<=1 for exactly one cycle, CmdReady<=1, Busy<=0, go to IDLE.
- Mosi is stable across the whole HIGH phase. No Sclk edge occurs while CSel=1.
- Timing per byte: CSel low for exactly 16*HalfPeriod cycles.
- Timing per packet, from the accept edge to the Done edge: 64*HalfPeriod + 3*ByteGap + PacketGap cycles.
- Back-to-back packets: if CmdValid is held high, the next packet is accepted on the first IDLE cycle (the Done cycle). Minimum CSel-high time between packets is therefore PacketGap+1 cycles.
- CmdValid dropping mid-transfer has no effect; the packet completes.
- Reset mid-transfer: abort immediately (CSel=1, Sclk=0 asynchronously). No Done is issued, and the partial byte is discarded.
- One phase counter (width ceil(log2(max(HalfPeriod,ByteGap,PacketGap)+1))), a 3-bit bit counter, a 2-bit byte counter and a 32-bit shift register.

Test Plan:
- HalfPeriod=1, ByteGap=1, PacketGap=8; send 0x41C0C0C0.
  - Required: four CSel-low windows of 16 cycles each, separated by 1-cycle high gaps.
  - Bits sampled on Sclk rises are 01000001, 11000000, 11000000, 11000000.
  - Done fires 64+3+8=75 cycles after accept.
- Send 0x41030303 back-to-back with 0x41C0C0C0, CmdValid held high.
  - Required: second accept on the Done cycle; CSel high exactly 9 cycles between packets.
  - Decoded bytes are 0x41, 0x03, 0x03, 0x03.
- HalfPeriod=3: send 0xA5000000.
  - Required: each Sclk level lasts 3 cycles.
  - Mosi changes only while Sclk=0; a checker flags any Mosi toggle with Sclk=1.
  - First byte decodes as 0xA5.
- Reset mid-packet: assert NReset=0 during HIGH of byte 1, bit 4.
  - Required: CSel=1 and Sclk=0 without waiting for a clock edge; no Done.
  - After release, CmdReady=1 on the next edge and a new packet 0x41FFFFFF transfers correctly.
- Idle behaviour: CmdValid=0 for 50 cycles.
  - Required: Sclk=0, CSel=1, Busy=0, CmdReady=1 throughout.
  - CmdData changes during a transfer do not alter the emitted bits.
